nibble_serial_cla_subtractor: RTL and testbench
===============================================

// Module: nibble_serial_cla_subtractor
//
// PURPOSE
//   Multi-cycle subtractor computing diff = a - b - bin for WIDTH-bit operands.
//   Processes one 4-bit slice per clock through a 4-bit carry-lookahead stage
//   (p = a ^ ~b, g = a & ~b, borrow carried between slices).
//   Shared arithmetic resource for datapath blocks that need subtraction
//   without a full-width combinational borrow chain.
//   Uses a start/busy/done handshake.
//
// PARAMETERS
//   WIDTH  16  operand/result width in bits; must be a multiple of 4, minimum 4
//
// PORTS
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous, active-high reset
//   start  in   1      request; sampled only when the FSM is in IDLE or DONE
//   a      in   WIDTH  minuend; captured on the accepted start edge
//   b      in   WIDTH  subtrahend; captured on the accepted start edge
//   bin    in   1      borrow-in; captured on the accepted start edge
//   busy   out  1      high while in RUN
//   done   out  1      one-cycle pulse; diff/bout/ovf are valid from this cycle
//   diff   out  WIDTH  a - b - bin, modulo 2^WIDTH
//   bout   out  1      unsigned borrow-out (1 when a < b + bin)
//   ovf    out  1      two's-complement overflow
//
// BEHAVIOUR
//   - Reset (async, takes effect immediately):
//     - FSM goes to IDLE; busy, done, diff, bout, ovf are all 0.
//     - Internal operand, shift and counter registers are cleared.
//   - FSM has three states: IDLE, RUN, DONE.
//     - IDLE -> RUN on start. Latch a, b, bin; set carry = ~bin; set slice count k = 0.
//     - RUN, at each edge:
//       - Compute slice k as a[4k+3:4k] + ~b[4k+3:4k] + carry, using explicit 4-bit CLA equations.
//       - Shift the 4-bit sum into the result register; update carry to c[3]; k++.
//     - RUN -> DONE on the edge that processes slice N-1 (N = WIDTH/4).
//       - On that same edge load diff, bout = ~carry_out, and ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
//     - DONE lasts exactly one cycle with done = 1, then goes to IDLE.
//       - If start = 1 during DONE, the new operands are accepted and the FSM goes directly to RUN.
//   - Latency: done rises N clock edges after the start-accepting edge (N = 4 for WIDTH = 16).
//     - Back-to-back throughput is one result per N+1 cycles.
//   - start while busy is ignored. The in-flight operation is unaffected, and no request is queued.
//   - Input changes after the accepting edge have no effect on the operation in flight.
//   - diff/bout/ovf hold their last value until the next completion. They are not cleared on start.
//   - busy = 1 exactly in RUN. done and busy are never high together.
//   - WIDTH = 4: a single RUN cycle; behaves as a registered 4-bit CLA subtractor.
//   - Reset asserted mid-RUN: the operation is discarded, done does not pulse, and outputs read 0.
//
// TESTING (WIDTH = 16)
//   1. a=0x0005, b=0x0003, bin=0 -> diff=0x0002, bout=0, ovf=0; done exactly 4 cycles after start; busy high for 4 cycles.
//   2. a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0.
//   3. a=0x8000, b=0x0001, bin=0 -> diff=0x7FFF, bout=0, ovf=1. Also a=0x7FFF, b=0xFFFF -> diff=0x8000, bout=1, ovf=1.
//   4. a=0x1234, b=0x1234, bin=1 -> diff=0xFFFF, bout=1. Also a=0xF0F0, b=0x0F0F, bin=0 -> diff=0xE1E1, bout=0, ovf=0.
//   5. Start 0xFFFF-0x0001, then pulse start with 0x0000-0x0000 at cycle 2 -> second start ignored; diff=0xFFFE.
//      Then assert start in the DONE cycle with 0x0010-0x0001 -> accepted; diff=0x000F 4 cycles later.
//   6. Assert rst in cycle 2 of RUN -> busy/done/diff/bout/ovf are 0 immediately, with no done pulse.
//      After release, 0x0009-0x0004 -> diff=0x0005.
//   - Every scenario is also checked against a reference model over 1000 random a/b/bin triples.

Source files
------------

// File: rtl/nibble_serial_cla_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, one 4-bit CLA slice per clock.
// start/busy/done handshake; results hold until the next completion.
module nibble_serial_cla_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int N  = WIDTH / 4;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_nx;
  logic [WIDTH-1:0] diff_q;
  logic             carry_q;
  logic             bout_q;
  logic             ovf_q;
  logic [KW-1:0]    k_q;

  logic             accept;
  logic             last;
  logic [3:0]       sa;
  logic [3:0]       sb;
  logic [3:0]       p;
  logic [3:0]       g;
  logic [3:0]       c;
  logic [3:0]       sum;

  // Subtraction as a + ~b + carry, carry-in of the first slice is ~bin.
  assign sa = a_q[3:0];
  assign sb = ~b_q[3:0];
  assign p  = sa ^ sb;
  assign g  = sa & sb;

  assign c[0] = g[0]
              | (p[0] & carry_q);
  assign c[1] = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & carry_q);
  assign c[2] = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & carry_q);
  assign c[3] = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & carry_q);

  assign sum = p ^ {c[2:0], carry_q};

  // New slice enters at the top; after N slices the LSB slice sits at bit 0.
  assign res_nx = (res_q >> 4)
                | (WIDTH'(sum) << (WIDTH - 4));

  assign last   = (k_q == KW'(N - 1));
  assign accept = start & (state != RUN);

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = RUN;
      RUN:  if (last) state_nx = DONE;
      DONE: state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      carry_q <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      k_q     <= '0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      carry_q <= ~bin;
      k_q     <= '0;
    end else if (state == RUN) begin
      a_q     <= a_q >> 4;
      b_q     <= b_q >> 4;
      carry_q <= c[3];
      k_q     <= k_q + KW'(1);
      res_q   <= res_nx;
      // On the last slice a_q/b_q bit 3 are the operand sign bits.
      if (last) begin
        diff_q <= res_nx;
        bout_q <= ~c[3];
        ovf_q  <= (a_q[3] ^ b_q[3])
                & (sum[3] ^ a_q[3]);
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_cla_subtractor.sv
// Directed and random checks for the nibble-serial subtractor (WIDTH = 16).
// Inputs change 1ns after a rising edge; outputs are sampled there too.
module tb_nibble_serial_cla_subtractor;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        busy;
  logic        done;
  logic [15:0] diff;
  logic        bout;
  logic        ovf;

  int nvec;
  int nmis;

  nibble_serial_cla_subtractor #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a request; returns 1ns after the edge that samples it.
  task automatic start_op(input logic [15:0] aa,
                          input logic [15:0] bb,
                          input logic bi);
    a = aa;
    b = bb;
    bin = bi;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Count edges until done, with a bound; flags busy&done overlap.
  task automatic wait_done(output int cyc, output int bcyc,
                           output int both);
    cyc = 0;
    bcyc = 0;
    both = 0;
    while (!done && cyc < 20) begin
      if (busy) bcyc++;
      if (busy && done) both++;
      tick();
      cyc++;
    end
    if (busy && done) both++;
  endtask

  task automatic run_vec(input string nm,
                         input logic [15:0] aa,
                         input logic [15:0] bb,
                         input logic bi,
                         input logic [15:0] ed,
                         input logic eb,
                         input logic eo);
    int cyc, bcyc, both;
    start_op(aa, bb, bi);
    wait_done(cyc, bcyc, both);
    nvec++;
    if (cyc !== 4 || bcyc !== 4 || both !== 0) begin
      nmis++;
      $display("FAIL %s timing: done_at=%0d busy_cycles=%0d overlap=%0d, need 4/4/0",
               nm, cyc, bcyc, both);
    end
    nvec++;
    if (diff !== ed || bout !== eb || ovf !== eo) begin
      nmis++;
      $display("FAIL %s result: diff=%h bout=%b ovf=%b, need diff=%h bout=%b ovf=%b",
               nm, diff, bout, ovf, ed, eb, eo);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;
    tick();
    tick();
    nvec++;
    if ({busy, done, diff, bout, ovf} !== 19'd0) begin
      nmis++;
      $display("FAIL reset: busy=%b done=%b diff=%h bout=%b ovf=%b, need all 0",
               busy, done, diff, bout, ovf);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    run_vec("t1_5m3", 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0);
    tick();
    nvec++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      nmis++;
      $display("FAIL t1_pulse: done=%b busy=%b, need 0/0", done, busy);
    end
    run_vec("t2_0m1", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_overflow();
    run_vec("t3_ovf_pos", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    tick();
    run_vec("t3_ovf_neg", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
    tick();
  endtask

  task automatic test_borrow();
    run_vec("t4_eq_bin", 16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    tick();
    run_vec("t4_f0f0", 16'hF0F0, 16'h0F0F, 1'b0, 16'hE1E1, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_back_to_back();
    int cyc, bcyc, both;
    start_op(16'hFFFF, 16'h0001, 1'b0);
    tick();
    start_op(16'h0000, 16'h0000, 1'b0);
    nvec++;
    if (busy !== 1'b1) begin
      nmis++;
      $display("FAIL t5_ignored_busy: busy=%b, need 1", busy);
    end
    wait_done(cyc, bcyc, both);
    nvec++;
    if (cyc !== 2 || diff !== 16'hFFFE || bout !== 1'b0) begin
      nmis++;
      $display("FAIL t5_first: edges=%0d diff=%h bout=%b, need 2/fffe/0",
               cyc, diff, bout);
    end
    // Request in the DONE cycle is taken straight into RUN.
    start_op(16'h0010, 16'h0001, 1'b0);
    nvec++;
    if (busy !== 1'b1 || done !== 1'b0 || diff !== 16'hFFFE) begin
      nmis++;
      $display("FAIL t5_accept_done: busy=%b done=%b diff=%h, need 1/0/fffe",
               busy, done, diff);
    end
    wait_done(cyc, bcyc, both);
    nvec++;
    if (cyc !== 4 || both !== 0 || diff !== 16'h000F || bout !== 1'b0 || ovf !== 1'b0) begin
      nmis++;
      $display("FAIL t5_second: edges=%0d overlap=%0d diff=%h bout=%b ovf=%b, need 4/0/000f/0/0",
               cyc, both, diff, bout, ovf);
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    int seen;
    start_op(16'h1234, 16'h0001, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    nvec++;
    if ({busy, done, diff, bout, ovf} !== 19'd0) begin
      nmis++;
      $display("FAIL t6_async_clear: busy=%b done=%b diff=%h bout=%b ovf=%b, need all 0",
               busy, done, diff, bout, ovf);
    end
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) seen++;
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done || busy) seen++;
    end
    nvec++;
    if (seen !== 0) begin
      nmis++;
      $display("FAIL t6_no_done: stray busy/done cycles=%0d, need 0", seen);
    end
    run_vec("t6_9m4", 16'h0009, 16'h0004, 1'b0, 16'h0005, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_random();
    logic [15:0] ra, rb, ed;
    logic        rbi, eb, eo;
    logic [16:0] full;
    int cyc, bcyc, both;
    int bad;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rbi = 1'($urandom);
      full = {1'b0, ra} - {1'b0, rb} - {16'd0, rbi};
      ed = full[15:0];
      eb = full[16];
      eo = (ra[15] != rb[15]) && (ed[15] != ra[15]);
      start_op(ra, rb, rbi);
      // Scramble inputs while the operation is in flight.
      a = ~ra;
      b = ~rb;
      bin = ~rbi;
      wait_done(cyc, bcyc, both);
      nvec++;
      if (cyc !== 4 || both !== 0 || diff !== ed || bout !== eb || ovf !== eo) begin
        nmis++;
        bad++;
        if (bad < 10)
          $display("FAIL rnd %h-%h-%b: diff=%h bout=%b ovf=%b edges=%0d, need %h/%b/%b/4",
                   ra, rb, rbi, diff, bout, ovf, cyc, ed, eb, eo);
      end
      if (i % 3 == 0) tick();
    end
  endtask

  initial begin
    nvec = 0;
    nmis = 0;
    test_reset();
    test_basic();
    test_overflow();
    test_borrow();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
